// File: rtl/fifo_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the round-robin FIFO read scheduler:
//   state_t   - scheduler FSM encoding (ARB / WAIT / SEND)
//   id_width  - width of a source index for a given number of sources
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        ARB  = 2'd0,   // pick the next eligible source
        WAIT = 2'd1,   // FIFO read issued, dout arrives this cycle
        SEND = 2'd2    // word presented downstream, waiting for out_ready
    } state_t;

    // Source index width; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_rr_arbiter_if
// Bundles the source-FIFO side and the downstream stream side of the
// scheduler.
//   src_empty  per-FIFO empty flag                (FIFOs -> scheduler)
//   src_dout   flattened FIFO read data, source i at [i*WIDTH +: WIDTH]
//   src_mask   1 = source eligible for grant      (control -> scheduler)
//   src_rd_en  one-hot FIFO read strobe           (scheduler -> FIFOs)
//   out_data   output word                        (scheduler -> consumer)
//   out_src    source index of out_data           (scheduler -> consumer)
//   out_valid  out_data/out_src valid             (scheduler -> consumer)
//   out_ready  consumer accepts the word          (consumer -> scheduler)
// Modports: master = scheduler side, slave = environment side.
// ---------------------------------------------------------------------------
interface fifo_rr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) ();

    logic [NUM_REQ-1:0]       src_empty;
    logic [NUM_REQ*WIDTH-1:0] src_dout;
    logic [NUM_REQ-1:0]       src_mask;
    logic [NUM_REQ-1:0]       src_rd_en;
    logic [WIDTH-1:0]         out_data;
    logic [ID_W-1:0]          out_src;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        input  src_empty, src_dout, src_mask, out_ready,
        output src_rd_en, out_data, out_src, out_valid
    );

    modport slave (
        output src_empty, src_dout, src_mask, out_ready,
        input  src_rd_en, out_data, out_src, out_valid
    );

endinterface

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first set bit of req,
// searching upward from last+1 and wrapping around.
//   req      request vector
//   last     index granted most recently (lowest priority now)
//   gnt_idx  index of the winning request (0 when none)
//   any      at least one request is set
// The request vector is doubled so the wrap-around search becomes a plain
// right shift followed by a lowest-set-bit search.
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               any
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [2*NUM_REQ-1:0] rot;
    int                   start;
    int                   pos;
    logic                 found;

    always_comb begin
        // NOTE: every variable gets a default before any branch so the
        // block can never hold a value between evaluations (no latch).
        dbl     = {req, req};
        start   = (int'(last) >= NUM_REQ - 1) ? 0 : int'(last) + 1;
        rot     = dbl >> start;
        pos     = 0;
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                pos   = start + k;
                if (pos >= NUM_REQ) begin
                    pos = pos - NUM_REQ;
                end
                gnt_idx = ID_W'(pos);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_rr_arbiter
// Round-robin read scheduler sharing one valid/ready consumer between
// NUM_REQ source FIFOs. A grant reads up to BURST words from one FIFO; each
// word is read with src_rd_en, captured from the registered FIFO dout one
// cycle later and presented on out_data/out_src/out_valid.
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous reset, active low
//   bus    fifo_rr_arbiter_if master (FIFO side + output stream)
//   busy   high while a grant is in progress (WAIT or SEND)
// ---------------------------------------------------------------------------
module fifo_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int BURST   = 4,
    parameter int ID_W    = id_width(NUM_REQ),
    parameter int CNT_W   = $clog2(BURST + 1)
) (
    input  logic              clk,
    input  logic              rst,
    fifo_rr_arbiter_if.master bus,
    output logic              busy
);

    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST);

    state_t             state_q, state_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [ID_W-1:0]    out_src_q, out_src_d;
    logic               out_valid_q, out_valid_d;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] rd_en;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_any;
    logic [WIDTH-1:0]   dout_sel;
    logic               can_continue;

    assign eligible = ~bus.src_empty & bus.src_mask;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req     (eligible),
        .last    (last_grant_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // Word of the granted FIFO; only meaningful in WAIT, because the FIFOs
    // drive zero on cycles without a read.
    assign dout_sel = WIDTH'(bus.src_dout >> (int'(grant_q) * WIDTH));

    // Burst may go on only while budget remains and the granted source is
    // still non-empty and unmasked; a mask drop therefore ends the grant at
    // the next handshake while the word already in flight is delivered.
    assign can_continue = (burst_cnt_q < BURST_MAX) &&
                          !bus.src_empty[grant_q] &&
                          bus.src_mask[grant_q];

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        out_valid_d  = out_valid_q;
        rd_en        = '0;

        case (state_q)
            ARB: begin
                if (pick_any) begin
                    rd_en[pick_idx] = 1'b1;
                    grant_d         = pick_idx;
                    burst_cnt_d     = CNT_W'(1);
                    state_d         = WAIT;
                end
            end

            WAIT: begin
                out_data_d  = dout_sel;
                out_src_d   = grant_q;
                out_valid_d = 1'b1;
                state_d     = SEND;
            end

            SEND: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (can_continue) begin
                        rd_en[grant_q] = 1'b1;
                        burst_cnt_d    = burst_cnt_q + CNT_W'(1);
                        state_d        = WAIT;
                    end else begin
                        last_grant_d = grant_q;
                        state_d      = ARB;
                    end
                end
            end

            default: begin
                out_valid_d = 1'b0;
                state_d     = ARB;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ARB;
            grant_q      <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            burst_cnt_q  <= '0;
            out_data_q   <= '0;
            out_src_q    <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            out_valid_q  <= out_valid_d;
        end
    end

    // The ARB branch is combinational on the FIFO flags, so the strobe is
    // also held low while reset is asserted; otherwise a FIFO could pop a
    // word during reset that nobody captures.
    assign bus.src_rd_en = rst ? rd_en : '0;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_valid = out_valid_q;
    assign busy          = (state_q != ARB);

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_rr_arbiter
// Directed bench for fifo_rr_arbiter (WIDTH=8, NUM_REQ=4, BURST=4).
// Four behavioural FIFOs with registered dout (zero on idle cycles) feed the
// scheduler; every accepted output word is logged with its clock cycle and
// compared against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_fifo_rr_arbiter;

    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;
    localparam int BURST   = 4;
    localparam int DEPTH   = 64;
    localparam int LOGSZ   = 128;

    logic clk;
    logic rst;
    logic busy;

    fifo_rr_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

    fifo_rr_arbiter #(
        .WIDTH   (WIDTH),
        .NUM_REQ (NUM_REQ),
        .BURST   (BURST)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- source FIFO models ----------------
    logic [7:0] mem [NUM_REQ][DEPTH];
    int         wr_ptr [NUM_REQ] = '{default: 0};
    int         rd_ptr [NUM_REQ] = '{default: 0};
    logic [7:0] fdout  [NUM_REQ] = '{default: 8'h00};
    logic       fempty [NUM_REQ] = '{default: 1'b1};
    logic       flush = 1'b0;

    assign bus.src_dout  = {fdout[3], fdout[2], fdout[1], fdout[0]};
    assign bus.src_empty = {fempty[3], fempty[2], fempty[1], fempty[0]};

    always @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (flush) begin
                rd_ptr[i] <= wr_ptr[i];
                fdout[i]  <= 8'h00;
                fempty[i] <= 1'b1;
            end else if (bus.src_rd_en[i]) begin
                fdout[i]  <= mem[i][rd_ptr[i] % DEPTH];
                rd_ptr[i] <= rd_ptr[i] + 1;
                fempty[i] <= (wr_ptr[i] == rd_ptr[i] + 1);
            end else begin
                fdout[i]  <= 8'h00;
                fempty[i] <= (wr_ptr[i] == rd_ptr[i]);
            end
        end
    end

    // ---------------- output / strobe monitor ----------------
    int         cyc = 0;
    int         log_n = 0;
    int         log_src  [LOGSZ];
    logic [7:0] log_data [LOGSZ];
    int         log_cyc  [LOGSZ];
    int         rd_cnt [NUM_REQ] = '{default: 0};
    int         viol_onehot = 0;
    int         viol_empty  = 0;
    int         viol_mask   = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.out_valid && bus.out_ready && log_n < LOGSZ) begin
            log_src[log_n]  <= int'(bus.out_src);
            log_data[log_n] <= bus.out_data;
            log_cyc[log_n]  <= cyc;
            log_n           <= log_n + 1;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.src_rd_en[i]) rd_cnt[i] <= rd_cnt[i] + 1;
        end
        if ($countones(bus.src_rd_en) > 1)             viol_onehot <= viol_onehot + 1;
        if ((bus.src_rd_en & bus.src_empty) != '0)     viol_empty  <= viol_empty + 1;
        if ((bus.src_rd_en & ~bus.src_mask) != '0)     viol_mask   <= viol_mask + 1;
    end

    // ---------------- checking helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int s, input logic [7:0] d);
        mem[s][wr_ptr[s] % DEPTH] = d;
        wr_ptr[s] = wr_ptr[s] + 1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_log(input int target, input int budget, input string tag);
        int k = 0;
        while (log_n < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, log_n, target);
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int k = 0;
        while (bus.out_valid !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, bus.out_valid, 1);
    endtask

    task automatic expect_word(input int idx, input int src, input logic [7:0] data, input string tag);
        check($sformatf("%s_src[%0d]", tag, idx), log_src[idx], src);
        check($sformatf("%s_data[%0d]", tag, idx), log_data[idx], data);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b0;
        flush = 1'b1;
        cycles(2);
        flush = 1'b0;
        rst   = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int r0, r1, r3;
        int bad_hold, bad_rd, bad_idle;
        int rr_src [12];
        int rr_gap [11];
        int mk_src [7];
        logic [7:0] mk_dat [7];

        rst           = 1'b0;
        bus.src_mask  = 4'b1111;
        bus.out_ready = 1'b1;
        cycles(2);

        // Reset state
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data",  bus.out_data,  0);
        check("rst_out_src",   bus.out_src,   0);
        check("rst_busy",      busy,          0);
        check("rst_rd_en",     bus.src_rd_en, 0);
        rst = 1'b1;

        // 1) Single source, three words
        base = log_n;
        r0   = rd_cnt[0];
        push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
        wait_log(base + 3, 40, "single_count");
        expect_word(base + 0, 0, 8'h11, "single");
        expect_word(base + 1, 0, 8'h22, "single");
        expect_word(base + 2, 0, 8'h33, "single");
        check("single_gap0", log_cyc[base + 1] - log_cyc[base + 0], 2);
        check("single_gap1", log_cyc[base + 2] - log_cyc[base + 1], 2);
        cycles(3);
        check("single_rd_en_count", rd_cnt[0] - r0, 3);
        check("single_idle_busy", busy, 0);

        // 2) Round robin between sources 0 and 2, six words each
        do_reset();
        base = log_n;
        for (int k = 0; k < 6; k++) begin
            push(0, 8'hA0 + 8'(k));
            push(2, 8'hC0 + 8'(k));
        end
        rr_src = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0, 2, 2};
        rr_gap = '{2, 2, 2, 3, 2, 2, 2, 3, 2, 3, 2};
        wait_log(base + 12, 120, "rr_count");
        begin
            int n0 = 0;
            int n2 = 0;
            for (int k = 0; k < 12; k++) begin
                if (rr_src[k] == 0) begin
                    expect_word(base + k, 0, 8'hA0 + 8'(n0), "rr");
                    n0++;
                end else begin
                    expect_word(base + k, 2, 8'hC0 + 8'(n2), "rr");
                    n2++;
                end
            end
        end
        for (int k = 0; k < 11; k++) begin
            check($sformatf("rr_gap[%0d]", k), log_cyc[base + k + 1] - log_cyc[base + k], rr_gap[k]);
        end

        // 3) Backpressure: ready low for 10 cycles after first out_valid
        do_reset();
        bus.out_ready = 1'b0;
        base = log_n;
        r1   = rd_cnt[1];
        push(1, 8'h51); push(1, 8'h52); push(1, 8'h53);
        wait_valid(40, "bp_first_valid");
        check("bp_first_data", bus.out_data, 8'h51);
        check("bp_first_src",  bus.out_src,  1);
        bad_hold = 0;
        bad_rd   = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_data !== 8'h51 || bus.out_valid !== 1'b1) bad_hold++;
            if (bus.src_rd_en !== 4'b0000) bad_rd++;
        end
        check("bp_hold_stable", bad_hold, 0);
        check("bp_no_rd_en",    bad_rd,   0);
        check("bp_rd_count_held", rd_cnt[1] - r1, 1);
        bus.out_ready = 1'b1;
        wait_log(base + 3, 40, "bp_count");
        expect_word(base + 0, 1, 8'h51, "bp");
        expect_word(base + 1, 1, 8'h52, "bp");
        expect_word(base + 2, 1, 8'h53, "bp");
        check("bp_gap0", log_cyc[base + 1] - log_cyc[base + 0], 2);
        check("bp_gap1", log_cyc[base + 2] - log_cyc[base + 1], 2);
        cycles(6);
        check("bp_no_dup", log_n, base + 3);
        check("bp_rd_count", rd_cnt[1] - r1, 3);

        // 4) Mask: only 0 and 2 eligible; drop source 0 after its first word
        do_reset();
        bus.out_ready = 1'b0;
        bus.src_mask  = 4'b0101;
        base = log_n;
        r1   = rd_cnt[1];
        r3   = rd_cnt[3];
        for (int k = 0; k < 6; k++) begin
            push(0, 8'hB0 + 8'(k));
            push(2, 8'hD0 + 8'(k));
        end
        for (int k = 0; k < 3; k++) begin
            push(1, 8'hE0 + 8'(k));
            push(3, 8'hF0 + 8'(k));
        end
        wait_valid(40, "mask_first_valid");
        check("mask_first_src", bus.out_src, 0);
        bus.src_mask  = 4'b0100;
        bus.out_ready = 1'b1;
        mk_src = '{0, 2, 2, 2, 2, 2, 2};
        mk_dat = '{8'hB0, 8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5};
        wait_log(base + 7, 120, "mask_count");
        for (int k = 0; k < 7; k++) begin
            expect_word(base + k, mk_src[k], mk_dat[k], "mask");
        end
        cycles(10);
        check("mask_no_more_words", log_n, base + 7);
        check("mask_idle_busy", busy, 0);
        check("mask_src1_never_read", rd_cnt[1] - r1, 0);
        check("mask_src3_never_read", rd_cnt[3] - r3, 0);

        // 5) Asynchronous reset while a word is presented
        do_reset();
        bus.src_mask  = 4'b1111;
        bus.out_ready = 1'b0;
        base = log_n;
        push(1, 8'h61); push(1, 8'h62); push(3, 8'h71);
        wait_valid(40, "arst_valid_before");
        check("arst_src_before", bus.out_src, 1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_out_valid_now", bus.out_valid, 0);
        check("arst_rd_en_now",     bus.src_rd_en, 0);
        check("arst_busy_now",      busy,          0);
        push(0, 8'h81);
        bus.out_ready = 1'b1;
        cycles(3);
        check("arst_rd_en_held", bus.src_rd_en, 0);
        check("arst_data_held",  bus.out_data,  0);
        rst = 1'b1;
        wait_log(base + 3, 60, "arst_count");
        expect_word(base + 0, 0, 8'h81, "arst");
        expect_word(base + 1, 1, 8'h62, "arst");
        expect_word(base + 2, 3, 8'h71, "arst");

        // 6) Idle, then source 3 followed by source 0 (priority wrap)
        cycles(2);
        base     = log_n;
        bad_idle = 0;
        bad_rd   = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0) bad_idle++;
            if (bus.src_rd_en !== 4'b0000) bad_rd++;
        end
        check("idle_busy",  bad_idle, 0);
        check("idle_rd_en", bad_rd,   0);
        check("idle_no_words", log_n, base);
        push(3, 8'h93);
        wait_log(base + 1, 40, "wrap_count3");
        push(0, 8'h90);
        wait_log(base + 2, 40, "wrap_count0");
        expect_word(base + 0, 3, 8'h93, "wrap");
        expect_word(base + 1, 0, 8'h90, "wrap");

        // Strobe legality over the whole run
        cycles(2);
        check("rd_en_onehot_violations", viol_onehot, 0);
        check("rd_en_empty_violations",  viol_empty,  0);
        check("rd_en_mask_violations",   viol_mask,   0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
